// File: rtl/full_adder.sv
// full_adder: registered WIDTH-bit ripple-carry adder; {carry, sum} = a + b + c one cycle later.
// Outputs come only from flops and clear asynchronously while rst is low.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  logic [WIDTH:0]   cy;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             carry_d, carry_q;
  assign cy[0] = c;
  // one classic full-adder cell per bit, carry rippling upward
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum_d[i] = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1]  = (a[i] & b[i]) | (a[i] & cy[i]) | (b[i] & cy[i]);
  end
  assign carry_d = cy[WIDTH];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end
  assign sum   = sum_q;
  assign carry = carry_q;
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed and random checks of full_adder at WIDTH 1, 4 and 8.
module tb_full_adder;
  logic       clk, rst;
  logic       a1, b1, c1, s1, co1;
  logic [3:0] a4, b4, s4;
  logic       c4, co4;
  logic [7:0] a8, b8, s8;
  logic       c8, co8;
  int n_cmp = 0;
  int n_err = 0;

  full_adder #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .sum(s1), .carry(co1));
  full_adder #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .a(a4), .b(b4), .c(c4), .sum(s4), .carry(co4));
  full_adder #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .sum(s8), .carry(co8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst = 1'b1;
    {a1, b1, c1} = 3'b111;
    a4 = 4'h1; b4 = 4'h1; c4 = 1'b1;
    a8 = 8'h01; b8 = 8'h01; c8 = 1'b1;
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({co1, s1} !== 2'b00) begin n_err++; $display("FAIL reset_hold1 cyc%0d: got carry=%b sum=%b exp 0 0", k, co1, s1); end
      n_cmp++;
      if ({co4, s4} !== 5'h00) begin n_err++; $display("FAIL reset_hold4 cyc%0d: got carry=%b sum=%h exp 0 0", k, co4, s4); end
    end
    @(negedge clk) rst = 1'b1;
    #1;
    n_cmp++;
    if ({co1, s1} !== 2'b00) begin n_err++; $display("FAIL reset_release_pre_edge: got carry=%b sum=%b exp 0 0", co1, s1); end
    @(posedge clk); #1;
    n_cmp++;
    if ({co1, s1} !== 2'b11) begin n_err++; $display("FAIL reset_first_load1: got carry=%b sum=%b exp 1 1", co1, s1); end
    n_cmp++;
    if ({co4, s4} !== 5'h03) begin n_err++; $display("FAIL reset_first_load4: got carry=%b sum=%h exp 0 3", co4, s4); end
  endtask

  task automatic test_exhaustive;
    logic [7:0] exp_s, exp_c;
    exp_s = 8'b1001_0110;
    exp_c = 8'b1110_1000;
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      {a1, b1, c1} = v[2:0];
      @(posedge clk); #1;
      n_cmp++;
      if ({co1, s1} !== {exp_c[v], exp_s[v]})
        begin n_err++; $display("FAIL exhaustive abc=%03b: got carry=%b sum=%b exp %b %b", v[2:0], co1, s1, exp_c[v], exp_s[v]); end
    end
  endtask

  task automatic test_latency_hold;
    @(negedge clk);
    {a1, b1, c1} = 3'b100;
    @(posedge clk); #1;
    n_cmp++;
    if ({co1, s1} !== 2'b01) begin n_err++; $display("FAIL latency_first: got carry=%b sum=%b exp 0 1", co1, s1); end
    #2 {a1, b1, c1} = 3'b111;
    #1;
    n_cmp++;
    if ({co1, s1} !== 2'b01) begin n_err++; $display("FAIL hold_midcycle: got carry=%b sum=%b exp 0 1", co1, s1); end
    @(posedge clk); #1;
    n_cmp++;
    if ({co1, s1} !== 2'b11) begin n_err++; $display("FAIL latency_next: got carry=%b sum=%b exp 1 1", co1, s1); end
  endtask

  task automatic test_async_reset;
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if ({co1, s1} !== 2'b00) begin n_err++; $display("FAIL async_assert: got carry=%b sum=%b exp 0 0", co1, s1); end
    @(posedge clk); #1;
    n_cmp++;
    if ({co1, s1} !== 2'b00) begin n_err++; $display("FAIL async_during: got carry=%b sum=%b exp 0 0", co1, s1); end
    @(negedge clk);
    {a1, b1, c1} = 3'b101;
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({co1, s1} !== 2'b00) begin n_err++; $display("FAIL async_post_release: got carry=%b sum=%b exp 0 0", co1, s1); end
    @(posedge clk); #1;
    n_cmp++;
    if ({co1, s1} !== 2'b10) begin n_err++; $display("FAIL async_first_load: got carry=%b sum=%b exp 1 0", co1, s1); end
  endtask

  task automatic test_wrap4;
    logic [3:0] ta [3];
    logic [3:0] tb [3];
    logic       tc [3];
    logic [4:0] te [3];
    ta = '{4'hF, 4'hF, 4'h3};
    tb = '{4'h1, 4'hF, 4'h4};
    tc = '{1'b0, 1'b1, 1'b1};
    te = '{5'h10, 5'h1F, 5'h08};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a4 = ta[k]; b4 = tb[k]; c4 = tc[k];
      @(posedge clk); #1;
      n_cmp++;
      if ({co4, s4} !== te[k])
        begin n_err++; $display("FAIL wrap4 #%0d: got carry=%b sum=%h exp %b %h", k, co4, s4, te[k][4], te[k][3:0]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] e1;
    logic [8:0] e8;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      {a1, b1, c1} = 3'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      e1 = 2'(a1) + 2'(b1) + 2'(c1);
      e8 = 9'(a8) + 9'(b8) + 9'(c8);
      @(posedge clk); #1;
      n_cmp++;
      if ({co1, s1} !== e1) begin n_err++; $display("FAIL rand1 #%0d: got %b%b exp %b", k, co1, s1, e1); end
      n_cmp++;
      if ({co8, s8} !== e8) begin n_err++; $display("FAIL rand8 #%0d a=%h b=%h c=%b: got carry=%b sum=%h exp %b %h", k, a8, b8, c8, co8, s8, e8[8], e8[7:0]); end
    end
  endtask

  initial begin
    test_reset;
    test_exhaustive;
    test_latency_hold;
    test_async_reset;
    test_wrap4;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
